imem_fetch_responder: RTL

- Responder end of the instruction-fetch interface: accepts word addresses from the fetch initiator (program counter) and returns 32-bit instruction words.
- Fixed-latency synchronous read from an internal word array, followed by an output FIFO.
- Full valid/ready backpressure on both sides.
- Side load port preloads program images for bring-up and benches.

---
 rtl/imem_fetch_responder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: fixed-latency word-array read feeding a small output FIFO,
// credit-based request throttling, plus a side load port. Optional flush under IMEM_FETCH_FLUSH_EN.
module imem_fetch_responder #(
    parameter int ADDR_WIDTH  = 30,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  rsp_err,
`ifdef IMEM_FETCH_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int NSTG  = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(NSTG + FIFO_DEPTH + 1);
    localparam logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(32'h0000_0013);

    logic                  flush_active;
    logic                  req_in_range;
    logic                  ld_in_range;
    logic [IDX_W-1:0]      req_idx;
    logic [IDX_W-1:0]      ld_idx;
    logic                  accept;
    logic                  pop;
    logic [INF_W-1:0]      inflight;

    logic                  push_valid;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic                  push_err;
    logic [DATA_WIDTH-1:0] push_data;

    logic [DATA_WIDTH-1:0] mem_array [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    logic [NSTG-1:0]       stg_valid_reg;
    logic [NSTG-1:0]       stg_err_reg;
    logic [ADDR_WIDTH-1:0] stg_addr_reg [NSTG];

    logic [DATA_WIDTH-1:0] fifo_data_reg [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_reg [FIFO_DEPTH];
    logic                  fifo_err_reg  [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;

`ifdef IMEM_FETCH_FLUSH_EN
    assign flush_active = flush;
`else
    assign flush_active = 1'b0;
`endif

    assign req_in_range = (req_addr < ADDR_WIDTH'(DEPTH_WORDS));
    assign ld_in_range  = (ld_addr < ADDR_WIDTH'(DEPTH_WORDS));
    assign req_idx      = req_addr[IDX_W-1:0];
    assign ld_idx       = ld_addr[IDX_W-1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit check: everything accepted but not yet consumed must fit in the FIFO,
    // so the read pipeline can advance unconditionally.
    always_comb begin
        inflight = INF_W'(count_reg);
        if (LATENCY > 1) begin
            for (int k = 0; k < NSTG; k++) begin
                inflight = inflight + INF_W'(stg_valid_reg[k]);
            end
        end
    end

    assign rsp_valid = (count_reg != '0) && !flush_active;
    assign pop       = rsp_valid && rsp_ready;
    assign req_ready = !flush_active && ((inflight - INF_W'(pop)) < INF_W'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;

    assign rsp_data = rsp_valid ? fifo_data_reg[rd_ptr_reg] : '0;
    assign rsp_addr = rsp_valid ? fifo_addr_reg[rd_ptr_reg] : '0;
    assign rsp_err  = rsp_valid ? fifo_err_reg[rd_ptr_reg]  : 1'b0;

    // Word array: the nonblocking write gives read-before-write on a same-address collision.
    always_ff @(posedge clk) begin
        if (ld_en && ld_in_range) begin
            mem_array[ld_idx] <= ld_data;
        end
        if (accept) begin
            if (req_in_range) begin
                rd_data_reg <= mem_array[req_idx];
            end else begin
                rd_data_reg <= NOP_WORD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid_reg <= '0;
            stg_err_reg   <= '0;
            for (int k = 0; k < NSTG; k++) begin
                stg_addr_reg[k] <= '0;
            end
        end else if (flush_active) begin
            stg_valid_reg <= '0;
        end else begin
            stg_valid_reg[0] <= accept;
            if (accept) begin
                stg_addr_reg[0] <= req_addr;
                stg_err_reg[0]  <= !req_in_range;
            end
            for (int k = 1; k < NSTG; k++) begin
                stg_valid_reg[k] <= stg_valid_reg[k-1];
                stg_addr_reg[k]  <= stg_addr_reg[k-1];
                stg_err_reg[k]   <= stg_err_reg[k-1];
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            // Single-cycle latency: the FIFO slot itself acts as the read register.
            assign push_valid = accept;
            assign push_addr  = req_addr;
            assign push_err   = !req_in_range;
            assign push_data  = req_in_range ? mem_array[req_idx] : NOP_WORD;
        end else if (LATENCY == 2) begin : g_one_stage
            assign push_valid = stg_valid_reg[0];
            assign push_addr  = stg_addr_reg[0];
            assign push_err   = stg_err_reg[0];
            assign push_data  = rd_data_reg;
        end else begin : g_deep
            logic [DATA_WIDTH-1:0] pipe_data_reg [LATENCY-2];
            always_ff @(posedge clk) begin
                pipe_data_reg[0] <= rd_data_reg;
                for (int k = 1; k < LATENCY - 2; k++) begin
                    pipe_data_reg[k] <= pipe_data_reg[k-1];
                end
            end
            assign push_valid = stg_valid_reg[NSTG-1];
            assign push_addr  = stg_addr_reg[NSTG-1];
            assign push_err   = stg_err_reg[NSTG-1];
            assign push_data  = pipe_data_reg[LATENCY-3];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push_valid && !flush_active) begin
            fifo_data_reg[wr_ptr_reg] <= push_data;
            fifo_addr_reg[wr_ptr_reg] <= push_addr;
            fifo_err_reg[wr_ptr_reg]  <= push_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush_active) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_valid) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push_valid, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule
